// File: rtl/pend_req_scheduler_if.sv
// Request/encoder/status bundle between the pending-request scheduler and its surroundings.
interface pend_req_scheduler_if;
  logic [3:0] req_in;
  logic       enc_w;
  logic       enc_y;
  logic [3:0] pend;
  logic       busy;
  logic [1:0] svc_idx;
  logic       done;
  logic       err;

  modport master (
    output req_in, enc_w, enc_y,
    input  pend, busy, svc_idx, done, err
  );

  modport slave (
    input  req_in, enc_w, enc_y,
    output pend, busy, svc_idx, done, err
  );
endinterface

// File: rtl/pend_req_scheduler.sv
// Captures request rising edges as sticky pending bits, lets an external priority encoder
// pick one, services it for SVC_CYCLES clocks, then clears its pending bit.
module pend_req_scheduler #(
  parameter int unsigned SVC_CYCLES = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  pend_req_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    CLEAR   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pend_q, pend_d;
  logic [3:0]       req_prev_q;
  logic [3:0]       rise;
  logic [3:0]       clr_mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       svc_idx_q, svc_idx_d;
  logic [1:0]       code;
  logic             err_q, err_d;

  assign rise = bus.req_in & ~req_prev_q;
  assign code = {bus.enc_w, bus.enc_y};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    svc_idx_d = svc_idx_q;
    err_d     = err_q;
    clr_mask  = '0;
    unique case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          if (pend_q[code]) begin
            svc_idx_d = code;
            cnt_d     = CNT_W'(SVC_CYCLES);
            state_d   = SERVICE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SERVICE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clr_mask = 4'b0001 << svc_idx_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new rising edge on the bit being cleared re-arms it.
    pend_d = (pend_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      req_prev_q <= '0;
      cnt_q      <= '0;
      svc_idx_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      req_prev_q <= bus.req_in;
      cnt_q      <= cnt_d;
      svc_idx_q  <= svc_idx_d;
      err_q      <= err_d;
    end
  end

  assign bus.pend    = pend_q;
  assign bus.svc_idx = svc_idx_q;
  assign bus.err     = err_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == CLEAR);

endmodule

// File: tb/tb_pend_req_scheduler.sv
// Randomized and scenario-driven bench for pend_req_scheduler against a timestamp-based model.
module tb_pend_req_scheduler;

  localparam int SVC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       force_en = 1'b0;
  logic [1:0] force_code = '0;

  int n_checks = 0;
  int n_errors = 0;

  pend_req_scheduler_if ifc ();

  pend_req_scheduler #(.SVC_CYCLES(SVC), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] top_code(input logic [3:0] p);
    if (p[3]) return 2'd3;
    if (p[2]) return 2'd2;
    if (p[1]) return 2'd1;
    return 2'd0;
  endfunction

  // External encoder, with an override used to provoke the error path.
  logic [1:0] enc_code;
  assign enc_code    = force_en ? force_code : top_code(ifc.pend);
  assign ifc.enc_w   = enc_code[1];
  assign ifc.enc_y   = enc_code[0];
  assign ifc.req_in  = req;

  // Reference model: a service is a time window [m_start, m_start+SVC] in edge counts.
  logic [3:0] m_pend, m_prev;
  logic [1:0] m_idx;
  logic       m_err, m_active;
  int         t, m_start;

  logic       rec_en = 1'b0;
  logic [1:0] done_idx[$];
  int         done_t[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_idx = '0; m_err = 1'b0;
    m_active = 1'b0; t = 0; m_start = 0;
  endtask

  task automatic model_edge();
    logic [3:0] clr;
    logic [1:0] c;
    clr = '0;
    if (m_active && (t - m_start) == SVC) begin
      clr[m_idx] = 1'b1;
      m_active = 1'b0;
    end else if (!m_active && m_pend != '0) begin
      c = force_en ? force_code : top_code(m_pend);
      if (m_pend[c]) begin
        m_idx = c;
        m_active = 1'b1;
        m_start = t + 1;
      end else begin
        m_err = 1'b1;
      end
    end
    m_pend = (m_pend & ~clr) | (req & ~m_prev);
    m_prev = req;
    t++;
  endtask

  task automatic check_all();
    check("pend",    32'(ifc.pend),    32'(m_pend));
    check("busy",    32'(ifc.busy),    32'(m_active));
    check("done",    32'(ifc.done),    32'(m_active && (t - m_start) == SVC));
    check("svc_idx", 32'(ifc.svc_idx), 32'(m_idx));
    check("err",     32'(ifc.err),     32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (rec_en && ifc.done === 1'b1) begin
      done_idx.push_back(ifc.svc_idx);
      done_t.push_back(t);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called just after an edge: asserts reset mid-cycle and checks outputs before any edge.
  task automatic mid_reset();
    #3;
    rst = 1'b1;
    #1;
    check("rst_pend", 32'(ifc.pend), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_err",  32'(ifc.err),  32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1;
    check("rst0_pend", 32'(ifc.pend), 32'd0);
    check("rst0_busy", 32'(ifc.busy), 32'd0);
    check("rst0_done", 32'(ifc.done), 32'd0);
    check("rst0_err",  32'(ifc.err),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Single request; level held high must not re-arm.
    req = 4'b0001;
    steps(12);

    // All four at once: service in priority order, 6 cycles apart.
    req = 4'b0000; step();
    done_idx.delete(); done_t.delete(); rec_en = 1'b1;
    req = 4'b1111;
    steps(28);
    rec_en = 1'b0;
    check("prio_cnt", 32'(done_idx.size()), 32'd4);
    if (done_idx.size() == 4) begin
      for (int i = 0; i < 4; i++) check("prio_idx", 32'(done_idx[i]), 32'(3 - i));
      for (int i = 1; i < 4; i++) check("prio_gap", 32'(done_t[i] - done_t[i-1]), 32'(SVC + 2));
    end
    check("prio_pend", 32'(ifc.pend), 32'd0);

    // No preemption: A arrives while D is in service.
    req = 4'b0000; step();
    done_idx.delete(); done_t.delete(); rec_en = 1'b1;
    req = 4'b0001; step();
    steps(2);
    req = 4'b1001;
    steps(14);
    rec_en = 1'b0;
    check("npre_cnt", 32'(done_idx.size()), 32'd2);
    if (done_idx.size() == 2) begin
      check("npre_first",  32'(done_idx[0]), 32'd0);
      check("npre_second", 32'(done_idx[1]), 32'd3);
    end

    // Set wins over clear: re-pulse B in its own CLEAR cycle.
    req = 4'b0000; step();
    done_idx.delete(); done_t.delete(); rec_en = 1'b1;
    req = 4'b0100; step();
    req = 4'b0000;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        step();
        if (ifc.done === 1'b1) seen = 1'b1;
      end
      check("swc_seen", 32'(seen), 32'd1);
    end
    req = 4'b0100; step();
    check("swc_pend2", 32'(ifc.pend[2]), 32'd1);
    steps(10);
    rec_en = 1'b0;
    check("swc_cnt", 32'(done_idx.size()), 32'd2);
    if (done_idx.size() == 2) check("swc_idx", 32'(done_idx[1]), 32'd2);

    // Error path: encoder points at a non-pending bit.
    req = 4'b0000; step();
    req = 4'b0001; step();
    force_en = 1'b1; force_code = 2'b10;
    step();
    check("err_set",  32'(ifc.err),  32'd1);
    check("err_idle", 32'(ifc.busy), 32'd0);
    check("err_pend", 32'(ifc.pend), 32'd1);
    force_en = 1'b0;
    steps(8);

    // Async reset in the middle of servicing with pend=1011.
    req = 4'b0000; step();
    req = 4'b1011; step();
    step();
    check("pre_rst_busy", 32'(ifc.busy), 32'd1);
    mid_reset();
    req = 4'b0000;

    // Random traffic, occasional encoder faults and resets.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] tog;
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 3) == 0);
      req = req ^ tog;
      force_en = ($urandom_range(0, 24) == 0);
      force_code = 2'($urandom_range(0, 3));
      step();
      if ($urandom_range(0, 199) == 0) begin
        force_en = 1'b0;
        mid_reset();
      end
    end
    force_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pend_req_scheduler.md
Name: pend_req_scheduler

Overview:
- Sequential front end for the 4-input priority encoder (inputs A,B,C,D; outputs W,Y).
- Captures rising edges on four request lines into sticky pending bits and drives those bits into the encoder.
- Reads back the encoder's 2-bit code, services the selected request for a fixed number of cycles, then clears its pending bit.
- Encoder mapping: A = 11 (highest priority), B = 10, C = 01, D = 00; all-zero input gives 00.

Parameters:
- SVC_CYCLES, 4, service duration in clocks (legal range 1..2^CNT_W-1; 0 illegal).
- CNT_W, 3, width of the service down-counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_in  input  4  request levels; [3]=A, [2]=B, [1]=C, [0]=D.
- enc_w  input  1  encoder output W (code MSB).
- enc_y  input  1  encoder output Y (code LSB).
- pend  output  4  pending bits to encoder: [3]→A, [2]→B, [1]→C, [0]→D.
- busy  output  1  high in SERVICE and CLEAR.
- svc_idx  output  2  code of the request being serviced.
- done  output  1  one-cycle pulse in CLEAR.
- err  output  1  sticky; encoder code pointed at a non-pending bit.

Behaviour:
- Reset (async, while rst=1): pend=0000, req_prev=0000, state=IDLE, counter=0, busy=0, svc_idx=00, done=0, err=0. Deasserting rst mid-service abandons the service; nothing is replayed.
- Edge capture, every cycle: rise = req_in & ~req_prev; req_prev <= req_in.
  - pend <= (pend & ~clr_mask) | rise.
  - Set wins over clear on the same bit in the same cycle (re-arm).
  - A level held high sets the bit only once.
- Code to bit: bit index = {enc_w, enc_y} (11→pend[3], 00→pend[0]). The encoder is combinational; its code is valid in the same cycle as pend.
- FSM, all transitions on the rising edge of clk:
  - IDLE: busy=0. If pend≠0, sample {enc_w,enc_y}.
    - If pend[code]=1: svc_idx<=code, counter<=SVC_CYCLES, go to SERVICE.
    - If pend[code]=0: err<=1, stay in IDLE.
    - If pend=0: stay in IDLE.
  - SERVICE: busy=1, counter decrements each cycle. When counter reaches 1, go to CLEAR. Occupancy is exactly SVC_CYCLES cycles.
  - CLEAR: busy=1, done=1, clr_mask = one-hot(svc_idx). Next state is IDLE.
- No preemption: higher-priority requests that arrive during SERVICE or CLEAR remain pending until the next IDLE selection.
- svc_idx holds its value through IDLE until the next capture.
- Latency, req_in rising before edge k with an idle scheduler:
  - pend set after edge k.
  - SERVICE entered after edge k+1.
  - done high in cycle k+1+SVC_CYCLES.
  - Back in IDLE after edge k+2+SVC_CYCLES.
- Back-to-back: with further bits pending, IDLE lasts exactly one cycle between services. Throughput is one request per SVC_CYCLES+2 cycles.
- err is cleared only by rst. It does not block further operation.
- Outputs are registered, except done and busy, which are decoded directly from state.

Test Plan:
- Reset: rst=1 async mid-cycle with pend=1011 in SERVICE → pend=0000, busy=0, done=0, err=0 immediately, without waiting for a clock edge.
- Single request: req_in 0000→0001 before edge 1, SVC_CYCLES=4 →
  - pend=0001 after edge 1.
  - busy=1 and svc_idx=00 after edge 2.
  - done=1 in cycle 6.
  - pend=0000 and busy=0 after edge 7.
  - Holding req_in=0001 does not re-arm.
- Priority order: req_in 0000→1111 in one cycle → services in order svc_idx=11, 10, 01, 00. Four done pulses spaced 6 cycles apart; final pend=0000.
- No preemption: D in service, A rises at SERVICE cycle 2 → D completes (done with svc_idx=00), then A is serviced next (svc_idx=11).
- Set-wins-clear: re-pulse B (req_in[2] 0→1) exactly in B's CLEAR cycle → pend[2] stays 1 and B is serviced again.
- Error path: bench-driven encoder forces {W,Y}=10 while pend=0001 → err=1 after the next edge, state stays IDLE, pend unchanged.
